matrix_fifo_drain: RTL and testbench
====================================

MATRIX_FIFO_DRAIN -- requirements
Module: matrix_fifo_drain

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8, pixel width; equals the matrix FIFO read width.
REQ-002 SHALL have parameter IMG_WIDTH, default 640, pixels per line.
REQ-003 SHALL have parameter IMG_HEIGHT, default 480, lines per frame.
REQ-004 SHALL have port rd_clk  input  1  single clock; one clock; reset is synchronous and active-high.
REQ-005 SHALL have port rd_rst  input  1  synchronous active-high reset.
REQ-006 SHALL have port start  input  1  one-cycle pulse that arms one frame drain.
REQ-007 SHALL have port fifo_rd_en  output  1  FIFO read enable.
REQ-008 SHALL have port fifo_rd_data  input  DATA_WIDTH  FIFO read data, valid exactly 1 cycle after fifo_rd_en (no output register).
REQ-009 SHALL have port fifo_rd_empty  input  1  FIFO empty flag.
REQ-010 SHALL have port m_valid  output  1  output pixel valid.
REQ-011 SHALL have port m_ready  input  1  downstream ready.
REQ-012 SHALL have port m_data  output  DATA_WIDTH  output pixel.
REQ-013 SHALL have ports m_sol, m_eol, m_sof, m_eof  output  1 each  start/end of line/frame markers, qualified by m_valid.
REQ-014 SHALL have ports col_cnt, row_cnt  output  clog2(IMG_WIDTH), clog2(IMG_HEIGHT)  position of m_data.
REQ-015 SHALL have ports busy, frame_done  output  1  drain active; one-cycle pulse after last pixel accepted.

Function
REQ-016 SHALL implement FSM IDLE -> RUN on start; RUN -> DONE on handshake (m_valid & m_ready) of pixel with m_eof; DONE -> IDLE after exactly 1 cycle.
REQ-017 SHALL ignore start in RUN and DONE.
REQ-018 SHALL hold a 2-entry output skid buffer; occ in 0..2; inflight = fifo_rd_en of previous cycle.
REQ-019 SHALL assert fifo_rd_en only when state=RUN, !fifo_rd_empty, issued < IMG_WIDTH*IMG_HEIGHT, and occ + inflight - pop < 2, where pop = m_valid & m_ready.
REQ-020 SHALL capture fifo_rd_data into the buffer in the cycle after each fifo_rd_en; never drop or duplicate a pixel.
REQ-021 SHALL sustain 1 pixel/cycle when FIFO non-empty and m_ready constantly high; first m_valid 2 cycles after start.
REQ-022 SHALL keep m_data and markers stable while m_valid & !m_ready.
REQ-023 SHALL advance col_cnt on each handshake, wrap IMG_WIDTH-1 -> 0 and increment row_cnt; row_cnt wraps IMG_HEIGHT-1 -> 0 at frame end.
REQ-024 SHALL set m_sol when col_cnt=0, m_eol when col_cnt=IMG_WIDTH-1, m_sof when both counters 0, m_eof when col_cnt=IMG_WIDTH-1 and row_cnt=IMG_HEIGHT-1.
REQ-025 SHALL never read beyond IMG_WIDTH*IMG_HEIGHT pixels per frame; FIFO empty mid-frame stalls issue without error.
REQ-026 SHALL assert busy in RUN and DONE; frame_done high only in DONE.

Reset
REQ-027 SHALL on rd_rst at clock edge: state IDLE, occ=0, inflight discarded, issued=0, counters 0, all outputs 0.
REQ-028 SHALL drop in-flight pixels on reset mid-frame; next frame begins at col 0 row 0.

Configuration
REQ-029 SHALL, with macro MATRIX_FIFO_DRAIN_STALL_CNT_EN defined, add output stall_cnt (16 bits) counting RUN cycles with fifo_rd_empty=1 and issued < total, saturating at 65535, cleared on start and reset.
REQ-030 SHALL, without MATRIX_FIFO_DRAIN_STALL_CNT_EN, omit stall_cnt port and logic; all other behaviour identical.

Verification (bench IMG_WIDTH=4, IMG_HEIGHT=2)
REQ-031 SHALL cover: FIFO preloaded 0x01..0x08, m_ready=1, start -> 8 pixels on 8 consecutive cycles, sof on 0x01, eol on 0x04/0x08, eof on 0x08, frame_done 1 cycle later.
REQ-032 SHALL cover: m_ready toggling 1010 -> output sequence 0x01..0x08 unchanged, data held while stalled, occ never >2.
REQ-033 SHALL cover: FIFO empty after 3 pixels for 5 cycles -> fifo_rd_en low, m_valid gaps, stall_cnt=5 with macro, resume at col 3.
REQ-034 SHALL cover: FIFO holds 12 pixels -> exactly 8 fifo_rd_en pulses; 4 remain in FIFO.
REQ-035 SHALL cover: rd_rst at pixel 5 -> all outputs 0 next cycle; new start yields sof on next FIFO word.

Source files
------------

// File: rtl/matrix_fifo_drain_if.sv
// matrix_fifo_drain_if: pixel stream from the drain to downstream, with markers and position.
interface matrix_fifo_drain_if #(
  parameter int DATA_WIDTH = 8,
  parameter int IMG_WIDTH  = 640,
  parameter int IMG_HEIGHT = 480
);
  logic                          m_valid;
  logic                          m_ready;
  logic [DATA_WIDTH-1:0]         m_data;
  logic                          m_sol;
  logic                          m_eol;
  logic                          m_sof;
  logic                          m_eof;
  logic [$clog2(IMG_WIDTH)-1:0]  col_cnt;
  logic [$clog2(IMG_HEIGHT)-1:0] row_cnt;
  modport master (output m_valid, m_data, m_sol, m_eol, m_sof, m_eof, col_cnt, row_cnt, input m_ready);
  modport slave  (input m_valid, m_data, m_sol, m_eol, m_sof, m_eof, col_cnt, row_cnt, output m_ready);
endinterface

// File: rtl/matrix_fifo_drain.sv
// matrix_fifo_drain: drains one frame from a matrix FIFO into a framed pixel stream.
// Define MATRIX_FIFO_DRAIN_STALL_CNT_EN to add the stall_cnt output.
module matrix_fifo_drain #(
  parameter int DATA_WIDTH = 8,
  parameter int IMG_WIDTH  = 640,
  parameter int IMG_HEIGHT = 480
) (
  input  logic                  rd_clk,
  input  logic                  rd_rst,
  input  logic                  start,
  output logic                  fifo_rd_en,
  input  logic [DATA_WIDTH-1:0] fifo_rd_data,
  input  logic                  fifo_rd_empty,
  matrix_fifo_drain_if.master   m,
  output logic                  busy,
  output logic                  frame_done
`ifdef MATRIX_FIFO_DRAIN_STALL_CNT_EN
  ,
  output logic [15:0]           stall_cnt
`endif
);
  localparam int CW    = $clog2(IMG_WIDTH);
  localparam int RW    = $clog2(IMG_HEIGHT);
  localparam int TOTAL = IMG_WIDTH * IMG_HEIGHT;
  localparam int IW    = $clog2(TOTAL + 1);
  localparam logic [1:0] IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2;
  logic [1:0]            r_state;
  logic [1:0]            r_occ;
  logic                  r_inflight;
  logic [IW-1:0]         r_issued;
  logic [CW-1:0]         r_col;
  logic [RW-1:0]         r_row;
  logic [DATA_WIDTH-1:0] r_buf [2];
  logic                  w_valid, w_pop, w_last_col, w_last_row, w_eof, w_more, w_wr_sel, w_arm;
  logic [2:0]            w_level;
  always_comb begin
    w_valid    = r_occ != 2'd0;
    w_pop      = w_valid & m.m_ready;
    w_last_col = r_col == CW'(IMG_WIDTH - 1);
    w_last_row = r_row == RW'(IMG_HEIGHT - 1);
    w_eof      = w_last_col & w_last_row;
    w_more     = r_issued < IW'(TOTAL);
    w_arm      = (r_state == IDLE) & start;
    // slots held plus the word arriving next cycle must fit the 2-entry buffer
    w_level    = {1'b0, r_occ} + {2'b0, r_inflight} - {2'b0, w_pop};
    w_wr_sel   = (r_occ == 2'd2) | ((r_occ == 2'd1) & !w_pop);
    fifo_rd_en = (r_state == RUN) & !fifo_rd_empty & w_more & (w_level < 3'd2);
    busy       = r_state != IDLE;
    frame_done = r_state == DONE;
  end
  assign m.m_valid = w_valid;
  assign m.m_data  = r_buf[0];
  assign m.col_cnt = r_col;
  assign m.row_cnt = r_row;
  assign m.m_sol   = w_valid & (r_col == '0);
  assign m.m_eol   = w_valid & w_last_col;
  assign m.m_sof   = w_valid & (r_col == '0) & (r_row == '0);
  assign m.m_eof   = w_valid & w_eof;
  always_ff @(posedge rd_clk) begin
    if (rd_rst) begin
      r_state    <= IDLE;
      r_occ      <= 2'd0;
      r_inflight <= 1'b0;
      r_issued   <= '0;
      r_col      <= '0;
      r_row      <= '0;
      r_buf[0]   <= '0;
      r_buf[1]   <= '0;
    end else begin
      r_inflight <= fifo_rd_en;
      r_occ      <= r_occ + {1'b0, r_inflight} - {1'b0, w_pop};
      r_state    <= w_arm ? RUN : (r_state == RUN && w_pop && w_eof) ? DONE : (r_state == DONE) ? IDLE : r_state;
      if (fifo_rd_en) r_issued <= r_issued + IW'(1);
      if (w_pop) begin
        r_buf[0] <= r_buf[1];
        r_col    <= w_last_col ? '0 : r_col + CW'(1);
        if (w_last_col) r_row <= w_last_row ? '0 : r_row + RW'(1);
      end
      if (r_inflight) r_buf[w_wr_sel] <= fifo_rd_data;
      if (w_arm) begin
        r_issued <= '0;
        r_col    <= '0;
        r_row    <= '0;
      end
    end
  end
`ifdef MATRIX_FIFO_DRAIN_STALL_CNT_EN
  always_ff @(posedge rd_clk) begin
    if (rd_rst || w_arm) stall_cnt <= '0;
    else if (r_state == RUN && fifo_rd_empty && w_more && stall_cnt != 16'hFFFF) stall_cnt <= stall_cnt + 16'd1;
  end
`endif
endmodule

// File: tb/tb_matrix_fifo_drain.sv
// tb_matrix_fifo_drain: FIFO model, pixel scoreboard and directed frame scenarios for a 4x2 image.
module tb_matrix_fifo_drain;
  localparam int W = 4, H = 2, N = W * H;
  logic clk = 0, rst = 1, start = 0, fifo_rd_en, fifo_rd_empty = 1, busy, frame_done;
  logic [7:0] fifo_rd_data = 0, fw, hold_data;
`ifdef MATRIX_FIFO_DRAIN_STALL_CNT_EN
  logic [15:0] stall_cnt;
`endif
  int checks = 0, errors = 0, k = 0, cyc = 0, frame_reads = 0;
  logic [7:0] q[$], sb[$];
  logic [7:0] acc_data [N];
  int acc_col [N], acc_cyc [N];
  logic exp_fd = 0, hold = 0, seen;
  matrix_fifo_drain_if #(.DATA_WIDTH(8), .IMG_WIDTH(W), .IMG_HEIGHT(H)) s();
  matrix_fifo_drain #(.DATA_WIDTH(8), .IMG_WIDTH(W), .IMG_HEIGHT(H)) dut (
    .rd_clk(clk), .rd_rst(rst), .start(start), .fifo_rd_en(fifo_rd_en),
    .fifo_rd_data(fifo_rd_data), .fifo_rd_empty(fifo_rd_empty), .m(s),
    .busy(busy), .frame_done(frame_done)
`ifdef MATRIX_FIFO_DRAIN_STALL_CNT_EN
    , .stall_cnt(stall_cnt)
`endif
  );
  always #5 clk = ~clk;
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask
  task automatic load(input logic [7:0] base, input int n);
    for (int i = 0; i < n; i++) q.push_back(base + 8'(i));
    fifo_rd_empty = (q.size() == 0);
  endtask
  task automatic pulse_start();
    @(posedge clk); #1 start = 1;
    @(posedge clk); #1 start = 0;
  endtask
  task automatic wait_done(input string nm);
    seen = 0;
    for (int i = 0; i < 200 && !seen; i++) begin
      @(negedge clk);
      seen = frame_done;
    end
    chk(nm, seen, 1);
  endtask
  task automatic chk_zero(input string nm);
    chk({nm, "_valid"}, s.m_valid, 0);
    chk({nm, "_data"}, s.m_data, 0);
    chk({nm, "_markers"}, {s.m_sol, s.m_eol, s.m_sof, s.m_eof}, 0);
    chk({nm, "_pos"}, {s.col_cnt, s.row_cnt}, 0);
    chk({nm, "_busy"}, busy, 0);
    chk({nm, "_done"}, frame_done, 0);
    chk({nm, "_rd_en"}, fifo_rd_en, 0);
`ifdef MATRIX_FIFO_DRAIN_STALL_CNT_EN
    chk({nm, "_stall"}, stall_cnt, 0);
`endif
  endtask
  // FIFO model: registered read data, one word per enable; words read during reset are lost
  always @(posedge clk) begin
    cyc++;
    if (fifo_rd_en && !fifo_rd_empty) begin
      fw = q.pop_front();
      fifo_rd_data <= fw;
      fifo_rd_empty <= (q.size() == 0);
      frame_reads++;
      if (!rst) sb.push_back(fw);
    end
  end
  always @(negedge clk) begin
    if (rst) begin
      sb.delete();
      k = 0;
      exp_fd = 0;
      hold = 0;
    end else begin
      chk("frame_done", frame_done, exp_fd);
      exp_fd = 0;
      if (fifo_rd_en) chk("rd_en_while_empty", fifo_rd_empty, 0);
      chk("occ_le2", sb.size() <= 2, 1);
      if (hold) begin
        chk("hold_valid", s.m_valid, 1);
        chk("hold_data", s.m_data, hold_data);
      end
      hold = s.m_valid & !s.m_ready;
      hold_data = s.m_data;
      if (s.m_valid) begin
        if (sb.size() == 0) chk("valid_without_read", 1, 0);
        else begin
          chk("data", s.m_data, sb[0]);
          chk("col", s.col_cnt, k % W);
          chk("row", s.row_cnt, k / W);
          chk("sol", s.m_sol, k % W == 0);
          chk("eol", s.m_eol, k % W == W - 1);
          chk("sof", s.m_sof, k == 0);
          chk("eof", s.m_eof, k == N - 1);
          chk("busy", busy, 1);
          if (s.m_ready) begin
            acc_data[k] = s.m_data;
            acc_col[k] = int'(s.col_cnt);
            acc_cyc[k] = cyc;
            void'(sb.pop_front());
            exp_fd = (k == N - 1);
            k = (k + 1) % N;
          end
        end
      end
    end
  end
  initial begin
    s.m_ready = 1;
    repeat (3) @(posedge clk);
    #1 rst = 0;
    @(negedge clk);
    chk_zero("reset");
    // full-rate frame
    load(8'h01, 8);
    pulse_start();
    @(negedge clk); chk("t1_lat0", s.m_valid, 0);
    @(negedge clk); chk("t1_lat1", s.m_valid, 0);
    for (int i = 0; i < N; i++) begin
      @(negedge clk);
      chk("t1_valid", s.m_valid, 1);
      chk("t1_data", s.m_data, i + 1);
      chk("t1_eol", s.m_eol, i == 3 || i == 7);
      chk("t1_sof", s.m_sof, i == 0);
      chk("t1_eof", s.m_eof, i == 7);
    end
    @(negedge clk); chk("t1_done", frame_done, 1); chk("t1_idle_valid", s.m_valid, 0);
    @(negedge clk); chk("t1_done_pulse", frame_done, 0); chk("t1_busy", busy, 0);
    // toggling backpressure
    load(8'h01, 8);
    pulse_start();
    seen = 0;
    for (int i = 0; i < 100 && !seen; i++) begin
      @(posedge clk); #1 s.m_ready = ~s.m_ready;
      seen = frame_done;
    end
    chk("t2_timeout", seen, 1);
    s.m_ready = 1;
    for (int i = 0; i < N; i++) chk("t2_seq", acc_data[i], i + 1);
    // FIFO runs dry after three pixels for five cycles
    load(8'h01, 3);
    pulse_start();
    for (int i = 0; i < 50 && q.size() != 0; i++) begin
      @(posedge clk); #1;
    end
    chk("t3_drained", q.size(), 0);
    repeat (5) begin
      @(posedge clk); #1 chk("t3_rd_en_low", fifo_rd_en, 0);
    end
    load(8'h04, 5);
    wait_done("t3_timeout");
    chk("t3_resume_data", acc_data[3], 8'h04);
    chk("t3_resume_col", acc_col[3], 3);
    chk("t3_gap", acc_cyc[3] - acc_cyc[2] > 1, 1);
`ifdef MATRIX_FIFO_DRAIN_STALL_CNT_EN
    chk("t3_stall_cnt", stall_cnt, 5);
`endif
    // surplus words stay in the FIFO
    frame_reads = 0;
    load(8'h20, 12);
    pulse_start();
    wait_done("t4_timeout");
    @(negedge clk);
    chk("t4_reads", frame_reads, 8);
    chk("t4_left", q.size(), 4);
    q.delete();
    fifo_rd_empty = 1;
    // reset mid-frame, then a fresh frame
    load(8'h01, 8);
    pulse_start();
    for (int i = 0; i < 50 && k != 5; i++) begin
      @(posedge clk); #1;
    end
    chk("t5_reach5", k, 5);
    rst = 1;
    @(posedge clk); #1 rst = 0;
    @(negedge clk);
    chk_zero("t5_reset");
    chk("t5_fifo_consumed", q.size(), 0);
    load(8'h11, 8);
    pulse_start();
    wait_done("t5_timeout");
    chk("t5_first", acc_data[0], 8'h11);
    chk("t5_last", acc_data[7], 8'h18);
    repeat (2) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
